// File: rtl/display7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are abcdefg packed into seg[6]..seg[0], active-low (0 = lit).
package display7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    unique case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/display7_scan_if.sv
// Host-side bundle of the scan driver.
//   value/dp_in/blank_mask/load : shadow-bank write port
//   blink_en/lz_en              : display mode levels
//   seg/dp/an/frame_sync        : registered, active-low display drive
// master = host/bench side, slave = display7_scan.
interface display7_scan_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic                  load;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_mask;
  logic                  blink_en;
  logic                  lz_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_sync;

  modport master (
    output value, load, dp_in, blank_mask, blink_en, lz_en,
    input  seg, dp, an, frame_sync
  );

  modport slave (
    input  value, load, dp_in, blank_mask, blink_en, lz_en,
    output seg, dp, an, frame_sync
  );
endinterface

// File: rtl/display7_hex.sv
// Combinational hex nibble to seven-segment decoder.
//   nib : 4-bit hex digit
//   seg : abcdefg pattern, active-low
module display7_hex
  import display7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb seg = hex_to_seg(nib);

endmodule

// File: rtl/display7_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : display7_scan_if.slave (write port, mode levels, display drive)
// A shadow bank absorbs loads; the active bank takes it only at the frame
// boundary, so a frame never shows a mix of old and new digits.
module display7_scan
  import display7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  display7_scan_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  wrap;
  logic                  wrap_q;

  logic [4*N_DIGITS-1:0] sh_val, ac_val;
  logic [N_DIGITS-1:0]   sh_dp, ac_dp;
  logic [N_DIGITS-1:0]   sh_bm, ac_bm;
  logic                  pending;

  logic [FW-1:0]         fcnt;
  logic                  blink_on;

  logic [N_DIGITS-1:0]   nz;
  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            nib_sel;
  seg_t                  hex_seg;
  logic                  dark;

  logic [N_DIGITS-1:0]   an_q;
  seg_t                  seg_q;
  logic                  dp_q;
  logic                  fs_q;

  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load coinciding with a commit is written after it, so the commit takes
  // the pre-load shadow and pending stays set for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_bm   <= '0;
      ac_val  <= '0;
      ac_dp   <= '0;
      ac_bm   <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        ac_val  <= sh_val;
        ac_dp   <= sh_dp;
        ac_bm   <= sh_bm;
        pending <= 1'b0;
      end
      if (bus.load) begin
        sh_val  <= bus.value;
        sh_dp   <= bus.dp_in;
        sh_bm   <= bus.blank_mask;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (!bus.blink_en) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // supp[k]: nibbles k..N-1 of the active word are all zero (digit 0 never).
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nz
    assign nz[g] = |ac_val[4*g +: 4];
  end
  assign supp[0] = 1'b0;
  for (genvar g = 1; g < N_DIGITS; g++) begin : g_supp
    assign supp[g] = ~|(nz >> g);
  end

  assign nib_sel = ac_val[{idx, 2'b00} +: 4];

  display7_hex u_hex (
    .nib (nib_sel),
    .seg (hex_seg)
  );

  // blink_en gates the phase directly so dropping it re-lights on the next clock.
  assign dark = ac_bm[idx] | (bus.lz_en & supp[idx]) | (bus.blink_en & ~blink_on);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap;
      fs_q   <= wrap_q;
      if (dark) begin
        an_q  <= '1;
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(N_DIGITS'(1) << idx);
        seg_q <= hex_seg;
        dp_q  <= ~ac_dp[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_sync = fs_q;

endmodule

// File: tb/tb_display7_scan.sv
// Self-checking bench for display7_scan (N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2).
// A cycle-count model predicts every output each clock; directed literal checks
// pin the model at hand-computed points.
module tb_display7_scan;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FR = N * R;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display7_scan_if #(.N_DIGITS(N)) bus ();

  display7_scan #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  logic [6:0] segtab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: n = clock edges since reset release.
  int         n = 0;
  logic [15:0] m_sh_v = '0, m_ac_v = '0;
  logic [3:0]  m_sh_dp = '0, m_ac_dp = '0, m_sh_bm = '0, m_ac_bm = '0;
  bit          m_pend = 1'b0, m_blink_on = 1'b1;
  int          m_frames = 0;

  logic [3:0]  e_an  = 4'b1111;
  logic [6:0]  e_seg = 7'b1111111;
  logic        e_dp  = 1'b1;
  logic        e_fs  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int d;
    bit dark;
    logic [15:0] sh;
    logic [3:0]  onehot;
    if (!rst_n) begin
      n = 0;
      m_sh_v = '0; m_ac_v = '0; m_sh_dp = '0; m_ac_dp = '0;
      m_sh_bm = '0; m_ac_bm = '0; m_pend = 1'b0;
      m_blink_on = 1'b1; m_frames = 0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      // Outputs after this edge show the digit lit during the cycle before it.
      d  = (n / R) % N;
      sh = m_ac_v >> (4 * d);
      dark = m_ac_bm[d] || (bus.lz_en && d != 0 && sh == 16'h0)
             || (bus.blink_en && !m_blink_on);
      if (dark) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        onehot = 4'b0001 << d;
        e_an   = ~onehot;
        e_seg  = segtab[sh[3:0]];
        e_dp   = ~m_ac_dp[d];
      end
      e_fs = (n > 0) && (n % FR == 0);
      if (n % FR == FR - 1) begin
        if (m_pend) begin
          m_ac_v = m_sh_v; m_ac_dp = m_sh_dp; m_ac_bm = m_sh_bm;
          m_pend = 1'b0;
        end
        if (bus.blink_en) begin
          m_frames++;
          if (m_frames == BF) begin
            m_frames = 0;
            m_blink_on = !m_blink_on;
          end
        end
      end
      if (!bus.blink_en) begin
        m_blink_on = 1'b1;
        m_frames = 0;
      end
      if (bus.load) begin
        m_sh_v = bus.value; m_sh_dp = bus.dp_in; m_sh_bm = bus.blank_mask;
        m_pend = 1'b1;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_an",  {28'h0, bus.an},  {28'h0, e_an});
      chk("cyc_seg", {25'h0, bus.seg}, {25'h0, e_seg});
      chk("cyc_dp",  {31'h0, bus.dp},  {31'h0, e_dp});
      chk("cyc_fs",  {31'h0, bus.frame_sync}, {31'h0, e_fs});
    end
  end

  initial begin
    #6 chk_en = 1'b1;
  end

  // Advance to just after edge t (counted from reset release).
  task automatic goto(input int t);
    if (t > n) begin
      repeat (t - n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bm);
    bus.value = v; bus.dp_in = dpv; bus.blank_mask = bm; bus.load = 1'b1;
    goto(n + 1);
    bus.load = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [3:0] an, input logic [6:0] seg);
    chk({nm, "_an"},  {28'h0, bus.an},  {28'h0, an});
    chk({nm, "_seg"}, {25'h0, bus.seg}, {25'h0, seg});
  endtask

  initial begin
    bus.value = '0; bus.load = 1'b0; bus.dp_in = '0; bus.blank_mask = '0;
    bus.blink_en = 1'b0; bus.lz_en = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    lit("rst", 4'b1111, 7'b1111111);
    chk("rst_dp", {31'h0, bus.dp}, 32'd1);
    rst_n = 1'b1;
    goto(1);  lit("rel1", 4'b1110, 7'b0000001);
    goto(4);  lit("rel4", 4'b1110, 7'b0000001);
    goto(5);  lit("rel5", 4'b1101, 7'b0000001);

    // Load/commit mid-frame
    do_load(16'h1A3F, 4'b0100, 4'b0000);
    goto(10); lit("old", 4'b1011, 7'b0000001);
    goto(16); chk("fs16", {31'h0, bus.frame_sync}, 32'd0);
    goto(17); chk("fs17", {31'h0, bus.frame_sync}, 32'd1);
              lit("new0", 4'b1110, 7'b0111000);
    goto(21); lit("new1", 4'b1101, 7'b0000110);
    goto(25); lit("new2", 4'b1011, 7'b0001000);
              chk("new2_dp", {31'h0, bus.dp}, 32'd0);
    goto(29); lit("new3", 4'b0111, 7'b1001111);

    // Second load coinciding with the wrap edge
    goto(39); do_load(16'h1111, 4'b0000, 4'b0000);
    goto(47); do_load(16'h2222, 4'b0000, 4'b0000);
    goto(49); lit("sim49", 4'b1110, 7'b1001111);
    goto(57); lit("sim57", 4'b1011, 7'b1001111);
    goto(65); lit("sim65", 4'b1110, 7'b0010010);

    // Leading-zero suppression
    bus.lz_en = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    goto(81); lit("lz0", 4'b1110, 7'b0000001);
    goto(85); lit("lz1", 4'b1101, 7'b0001111);
    goto(89); lit("lz2", 4'b1111, 7'b1111111);
    goto(93); lit("lz3", 4'b1111, 7'b1111111);
    goto(97); do_load(16'h0000, 4'b0000, 4'b0000);
    goto(113); lit("lzz0", 4'b1110, 7'b0000001);
    goto(117); lit("lzz1", 4'b1111, 7'b1111111);
    goto(125); lit("lzz3", 4'b1111, 7'b1111111);
    bus.lz_en = 1'b0;

    // Blink
    goto(129); bus.blink_en = 1'b1;
    goto(150); lit("bl150", 4'b1101, 7'b0000001);
    goto(161); lit("bl161", 4'b1111, 7'b1111111);
    goto(192); lit("bl192", 4'b1111, 7'b1111111);
    goto(193); lit("bl193", 4'b1110, 7'b0000001);
    goto(230); lit("bl230", 4'b1111, 7'b1111111);
    bus.blink_en = 1'b0;
    goto(231); lit("bloff", 4'b1101, 7'b0000001);

    // Blank mask
    goto(233); do_load(16'h0000, 4'b0000, 4'b0010);
    goto(241); lit("bm0", 4'b1110, 7'b0000001);
    goto(245); lit("bm1", 4'b1111, 7'b1111111);
    goto(249); lit("bm2", 4'b1011, 7'b0000001);

    // Mid-frame reset; a load held during reset must be ignored
    goto(250);
    rst_n = 1'b0;
    #1;
    lit("mrst", 4'b1111, 7'b1111111);
    chk("mrst_dp", {31'h0, bus.dp}, 32'd1);
    chk("mrst_fs", {31'h0, bus.frame_sync}, 32'd0);
    bus.value = 16'hFFFF; bus.blank_mask = 4'b1111; bus.load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit("mrst3", 4'b1111, 7'b1111111);
    bus.load = 1'b0; bus.value = '0; bus.blank_mask = '0;
    rst_n = 1'b1;
    goto(1);  lit("mrel1", 4'b1110, 7'b0000001);
    goto(20); lit("mrel20", 4'b1110, 7'b0000001);
    goto(24);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
